ray_dispatch_sched: RTL and testbench

Scheduler on the read side of the ray-direction FIFO (RayDirection entries).
- Pops one ray at a time from the FIFO.
- Absorbs the FIFO's 1-cycle registered read latency.
- Hands each ray to one of NUM_UNITS intersection units using a round-robin valid/ready handshake.
- Sits between the ray-generation FIFO and the intersection-unit array.

---
 rtl/ray_dispatch_sched_pkg.sv | 22 ++
 rtl/ray_dispatch_sched_if.sv | 44 ++++
 rtl/ray_dispatch_sched_rr_arbiter.sv | 27 ++
 rtl/ray_dispatch_sched.sv | 128 ++++++++++++
 tb/tb_ray_dispatch_sched.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ray_dispatch_sched_pkg.sv
// Shared types for the ray dispatch scheduler: ray payload, FSM states, component width.
`ifndef WIDTH
`define WIDTH 16
`endif

package ray_dispatch_sched_pkg;

    localparam int unsigned RD_W = `WIDTH;

    typedef struct packed {
        logic [RD_W-1:0] x;
        logic [RD_W-1:0] y;
        logic [RD_W-1:0] z;
    } RayDirection;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_OFFER = 2'd2
    } sched_state_t;

endpackage

// File: rtl/ray_dispatch_sched_if.sv
// FIFO-side and unit-side signals of the ray dispatch scheduler.
// RAY_DISPATCH_STATS_EN adds the per-unit hit and stall counters.
interface ray_dispatch_sched_if #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned CNT_W     = 32
);
    import ray_dispatch_sched_pkg::*;

    localparam int unsigned ID_W = $clog2(NUM_UNITS);

    logic                 enable_in;
    logic                 fifo_ready_in;
    logic                 fifo_read_out;
    RayDirection          fifo_rd_in;
    logic [NUM_UNITS-1:0] unit_ready_in;
    logic [NUM_UNITS-1:0] unit_valid_out;
    RayDirection          unit_rd_out;
    logic [ID_W-1:0]      unit_id_out;
    logic                 busy_out;
    logic [CNT_W-1:0]     dispatched_count_out;
`ifdef RAY_DISPATCH_STATS_EN
    logic [CNT_W-1:0]     unit_hits_out [NUM_UNITS];
    logic [CNT_W-1:0]     stall_cycles_out;
`endif

    modport slave (
        input  enable_in, fifo_ready_in, fifo_rd_in, unit_ready_in,
        output fifo_read_out, unit_valid_out, unit_rd_out, unit_id_out,
               busy_out, dispatched_count_out
`ifdef RAY_DISPATCH_STATS_EN
        , output unit_hits_out, stall_cycles_out
`endif
    );

    modport master (
        output enable_in, fifo_ready_in, fifo_rd_in, unit_ready_in,
        input  fifo_read_out, unit_valid_out, unit_rd_out, unit_id_out,
               busy_out, dispatched_count_out
`ifdef RAY_DISPATCH_STATS_EN
        , input unit_hits_out, stall_cycles_out
`endif
    );

endinterface

// File: rtl/ray_dispatch_sched_rr_arbiter.sv
// Combinational round-robin search: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any_grant
);

    int unsigned w_idx;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        w_idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = (32'(ptr) + i) % N;
            if (!any_grant && req[w_idx[IW-1:0]]) begin
                any_grant = 1'b1;
                grant     = w_idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/ray_dispatch_sched.sv
// Pops rays from the direction FIFO and hands each to one intersection unit, round-robin.
// RAY_DISPATCH_STATS_EN adds per-unit accepted counts and an offer-stall counter.
module ray_dispatch_sched
    import ray_dispatch_sched_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    ray_dispatch_sched_if.slave bus
);

    localparam int unsigned ID_W = $clog2(NUM_UNITS);

    sched_state_t     r_state;
    sched_state_t     w_next_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_grant;
    logic             r_lock;
    RayDirection      r_hold;
    logic [CNT_W-1:0] r_count;

    logic [ID_W-1:0]  w_arb_idx;
    logic             w_arb_any;
    logic [ID_W-1:0]  w_grant;
    logic             w_offering;
    logic             w_xfer;
    logic             w_pop;

    rr_arbiter #(.N(NUM_UNITS)) u_arb (
        .req       (bus.unit_ready_in),
        .ptr       (r_rr_ptr),
        .grant     (w_arb_idx),
        .any_grant (w_arb_any)
    );

    // Once locked the grant is frozen; before that the arbiter result is used directly
    // so that locking and transfer can happen in the same cycle.
    always_comb begin
        w_grant    = r_lock ? r_grant : w_arb_idx;
        w_offering = (r_state == S_OFFER) && (r_lock || w_arb_any);
        w_xfer     = w_offering && bus.unit_ready_in[w_grant];
        w_pop      = ((r_state == S_IDLE) || w_xfer) && bus.enable_in && bus.fifo_ready_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_pop) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_OFFER;
            S_OFFER: if (w_xfer) w_next_state = w_pop ? S_LOAD : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_read_out        = w_pop;
        bus.unit_valid_out       = '0;
        bus.unit_id_out          = '0;
        if (w_offering) begin
            bus.unit_valid_out[w_grant] = 1'b1;
            bus.unit_id_out             = w_grant;
        end
        bus.unit_rd_out          = r_hold;
        bus.busy_out             = (r_state != S_IDLE);
        bus.dispatched_count_out = r_count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_lock   <= 1'b0;
            r_hold   <= '0;
            r_count  <= '0;
        end else begin
            if (r_state == S_LOAD) begin
                r_hold <= bus.fifo_rd_in;
            end
            if (w_xfer) begin
                r_rr_ptr <= (w_grant == ID_W'(NUM_UNITS - 1)) ? '0 : w_grant + 1'b1;
                r_lock   <= 1'b0;
                r_count  <= r_count + 1'b1;
            end else if (w_offering && !r_lock) begin
                r_lock  <= 1'b1;
                r_grant <= w_arb_idx;
            end
        end
    end

`ifdef RAY_DISPATCH_STATS_EN
    logic [CNT_W-1:0] r_hits [NUM_UNITS];
    logic [CNT_W-1:0] r_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_UNITS; i++) begin
                r_hits[i] <= '0;
            end
            r_stall <= '0;
        end else begin
            if (w_xfer) begin
                r_hits[w_grant] <= r_hits[w_grant] + 1'b1;
            end
            if ((r_state == S_OFFER) && !w_xfer) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            bus.unit_hits_out[i] = r_hits[i];
        end
        bus.stall_cycles_out = r_stall;
    end
`endif

endmodule

// File: tb/tb_ray_dispatch_sched.sv
// Directed and random checks of ray_dispatch_sched against a transaction-level model.
module tb_ray_dispatch_sched;
    import ray_dispatch_sched_pkg::*;

    localparam int unsigned NU = 4;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ray_dispatch_sched_if #(.NUM_UNITS(NU), .CNT_W(CW)) bus ();

    ray_dispatch_sched #(.NUM_UNITS(NU), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    RayDirection fifo_q[$];

    // Model: ray stage 0 = none, 1 = popped (data arriving), 2 = being offered
    int unsigned     m_stage;
    int unsigned     m_ptr;
    int unsigned     m_grant;
    bit              m_locked;
    RayDirection     m_ray;
    longint unsigned m_count;

    int unsigned log_unit[$];
    RayDirection log_ray[$];
    int unsigned pop_cyc[$];
    int unsigned cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic RayDirection rand_ray();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[$bits(RayDirection)-1:0];
    endfunction

    task automatic push_ray(input RayDirection r);
        fifo_q.push_back(r);
        bus.fifo_ready_in = 1'b1;
    endtask

    task automatic model_reset();
        m_stage  = 0;
        m_ptr    = 0;
        m_grant  = 0;
        m_locked = 0;
        m_count  = 0;
    endtask

    task automatic cycle(input bit en, input logic [NU-1:0] rdy, input bit rst);
        logic [NU-1:0] exp_valid;
        int unsigned   exp_id;
        bit            xfer;
        bit            exp_read;
        bit            dut_read;
        bus.enable_in     = en;
        bus.unit_ready_in = rdy;
        reset             = rst;
        @(negedge clk);
        exp_valid = '0;
        exp_id    = 0;
        xfer      = 0;
        if (m_stage == 2 && !m_locked) begin
            for (int unsigned k = 0; k < NU; k++) begin
                int unsigned u;
                u = (m_ptr + k) % NU;
                if (!m_locked && rdy[u]) begin
                    m_locked = 1;
                    m_grant  = u;
                end
            end
        end
        if (m_stage == 2 && m_locked) begin
            exp_valid[m_grant] = 1'b1;
            exp_id             = m_grant;
            xfer               = rdy[m_grant];
        end
        exp_read = en && (fifo_q.size() > 0) && (m_stage == 0 || xfer);
        dut_read = bus.fifo_read_out;
        check("valid", bus.unit_valid_out, exp_valid);
        check("unit_id", bus.unit_id_out, exp_id);
        if (m_stage == 2 && m_locked) check("ray", bus.unit_rd_out, m_ray);
        check("fifo_read", dut_read, exp_read);
        check("busy", bus.busy_out, m_stage != 0);
        check("count", bus.dispatched_count_out, m_count[CW-1:0]);
        if (xfer) begin
            log_unit.push_back(m_grant);
            log_ray.push_back(m_ray);
            m_count++;
            m_ptr    = (m_grant + 1) % NU;
            m_locked = 0;
            m_stage  = 0;
        end else if (m_stage == 1) begin
            m_stage = 2;
        end
        if (exp_read) begin
            m_ray   = fifo_q[0];
            m_stage = 1;
            pop_cyc.push_back(cyc);
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
        if (dut_read && fifo_q.size() > 0) bus.fifo_rd_in = fifo_q.pop_front();
        bus.fifo_ready_in = (fifo_q.size() > 0);
        cyc++;
    endtask

    task automatic clear_logs();
        log_unit.delete();
        log_ray.delete();
        pop_cyc.delete();
    endtask

    initial begin
        RayDirection exp1[$];
        RayDirection r;

        reset             = 1'b1;
        bus.enable_in     = 1'b0;
        bus.unit_ready_in = '0;
        bus.fifo_ready_in = 1'b0;
        bus.fifo_rd_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("rst_valid", bus.unit_valid_out, 0);
        check("rst_read", bus.fifo_read_out, 0);
        check("rst_busy", bus.busy_out, 0);
        check("rst_count", bus.dispatched_count_out, 0);
        check("rst_rd", bus.unit_rd_out, 0);
        check("rst_id", bus.unit_id_out, 0);

        // Three rays, all units ready: pops every other cycle, units 0,1,2
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            r = rand_ray();
            exp1.push_back(r);
            push_ray(r);
        end
        repeat (8) cycle(1'b1, 4'b1111, 1'b0);
        check("s1_n", log_unit.size(), 3);
        check("s1_pops", pop_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("s1_unit", log_unit[i], i);
            check("s1_data", log_ray[i], exp1[i]);
        end
        check("s1_gap1", pop_cyc[1] - pop_cyc[0], 2);
        check("s1_gap2", pop_cyc[2] - pop_cyc[1], 2);
        check("s1_count", bus.dispatched_count_out, 3);

        // No unit ready for a while, then only unit 2
        clear_logs();
        push_ray(rand_ray());
        repeat (7) cycle(1'b1, 4'b0000, 1'b0);
        check("s2_idle_valid", bus.unit_valid_out, 0);
        check("s2_held", log_unit.size(), 0);
        cycle(1'b1, 4'b0100, 1'b0);
        check("s2_n", log_unit.size(), 1);
        check("s2_unit", log_unit[0], 2);

        // Pointer at 3 with units 0 and 3 ready: 3 first, then wrap to 0
        clear_logs();
        push_ray(rand_ray());
        push_ray(rand_ray());
        repeat (6) cycle(1'b1, 4'b1001, 1'b0);
        check("s4_n", log_unit.size(), 2);
        check("s4_first", log_unit[0], 3);
        check("s4_wrap", log_unit[1], 0);

        // Pointer at 1 with units 1 and 3 ready: unit 1 wins
        clear_logs();
        push_ray(rand_ray());
        repeat (2) cycle(1'b1, 4'b0000, 1'b0);
        repeat (3) cycle(1'b1, 4'b1010, 1'b0);
        check("s3_n", log_unit.size(), 1);
        check("s3_unit", log_unit[0], 1);

        // enable dropped while the ray is loading: it still goes out, no new pops
        clear_logs();
        push_ray(rand_ray());
        push_ray(rand_ray());
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0);
        repeat (4) cycle(1'b0, 4'b1111, 1'b0);
        check("s5_n", log_unit.size(), 1);
        check("s5_unit", log_unit[0], 2);
        check("s5_pops", pop_cyc.size(), 1);
        check("s5_fifo_left", fifo_q.size(), 1);

        // Reset while offering discards the ray; popping resumes afterwards
        clear_logs();
        repeat (4) cycle(1'b1, 4'b0000, 1'b0);
        check("s6_busy_before", bus.busy_out, 1);
        cycle(1'b1, 4'b0000, 1'b1);
        bus.enable_in = 1'b0;
        #1;
        check("s6_valid", bus.unit_valid_out, 0);
        check("s6_busy", bus.busy_out, 0);
        check("s6_count", bus.dispatched_count_out, 0);
        check("s6_rd", bus.unit_rd_out, 0);
        check("s6_read", bus.fifo_read_out, 0);
        push_ray(rand_ray());
        repeat (5) cycle(1'b1, 4'b1111, 1'b0);
        check("s6_resume_n", log_unit.size(), 1);
        check("s6_resume_unit", log_unit[0], 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 2) == 0) push_ray(rand_ray());
            cycle($urandom_range(0, 3) != 0, NU'($urandom()), $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
